// File: rtl/gpu_ucode_sequencer_if.sv
// Handshake and bus signals between the microcode sequencer and its environment:
// control inputs, ROM address/data, the issued uop and the VRAM read request.
interface gpu_ucode_sequencer_if;
    logic        iStart;
    logic        iStop;
    logic        iStall;
    logic        iZero;
    logic        iVmemAck;
    logic [19:0] iUop;
    logic [7:0]  oAddr;
    logic [19:0] oUop;
    logic        oUopValid;
    logic        oVmemReq;
    logic        oBusy;

    // Sequencer side: consumes control/ROM data, produces address and uop stream.
    modport slave (
        input  iStart, iStop, iStall, iZero, iVmemAck, iUop,
        output oAddr, oUop, oUopValid, oVmemReq, oBusy
    );

    // Environment side: drives control and ROM data, observes the sequencer.
    modport master (
        output iStart, iStop, iStall, iZero, iVmemAck, iUop,
        input  oAddr, oUop, oUopValid, oVmemReq, oBusy
    );
endinterface

// File: rtl/gpu_ucode_sequencer.sv
// GPU microcode sequencer: walks a 256-entry ucode ROM, issues uops to the
// execute stage, resolves unconditional and zero-flag branches and parks on
// VRAM reads until acknowledged. oAddr (the PC) is the only combinational output.
module gpu_ucode_sequencer #(
    parameter logic [7:0] START_ADDR = 8'd1,
    parameter logic [4:0] OP_GOTO    = 5'd2,
    parameter logic [4:0] OP_JZ      = 5'd3,
    parameter logic [4:0] OP_JNZ     = 5'd4,
    parameter logic [4:0] OP_RVMEM   = 5'd5,
    parameter logic [4:0] OP_NOP     = 5'd1
) (
    input  logic                   iClock,
    input  logic                   iReset,
    gpu_ucode_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_BR_EVAL   = 2'd2,
        ST_WAIT_VMEM = 2'd3
    } state_t;

    state_t      state_q;
    logic [7:0]  pc_q;
    logic [19:0] uop_q;
    logic        uop_valid_q;
    logic        vmem_req_q;
    logic        busy_q;
    logic [7:0]  target_q;
    logic        br_is_jz_q;

    logic [4:0]  opcode_s;
    logic [7:0]  target_s;
    logic [7:0]  pc_inc_s;
    logic        br_taken_s;

    // Uop decode fields; bits [14:8] carry no meaning for the sequencer.
    assign opcode_s   = bus.iUop[19:15];
    assign target_s   = bus.iUop[7:0];
    // 8-bit increment wraps 8'hFF to 8'h00 naturally.
    assign pc_inc_s   = pc_q + 8'd1;
    // JZ branches on a set zero flag, JNZ on a clear one.
    assign br_taken_s = br_is_jz_q ? bus.iZero : ~bus.iZero;

    assign bus.oAddr     = pc_q;
    assign bus.oUop      = uop_q;
    assign bus.oUopValid = uop_valid_q;
    assign bus.oVmemReq  = vmem_req_q;
    assign bus.oBusy     = busy_q;

    // Sequencer FSM with all outputs registered; reset beats stop, stop beats everything else.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q     <= ST_IDLE;
            pc_q        <= 8'd0;
            uop_q       <= 20'd0;
            uop_valid_q <= 1'b0;
            vmem_req_q  <= 1'b0;
            busy_q      <= 1'b0;
            target_q    <= 8'd0;
            br_is_jz_q  <= 1'b0;
        end else if (bus.iStop) begin
            // Any outstanding VRAM request is simply dropped.
            state_q     <= ST_IDLE;
            pc_q        <= 8'd0;
            uop_valid_q <= 1'b0;
            vmem_req_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    uop_valid_q <= 1'b0;
                    vmem_req_q  <= 1'b0;
                    if (bus.iStart) begin
                        pc_q    <= START_ADDR;
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        pc_q    <= 8'd0;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (bus.iStall) begin
                        uop_valid_q <= 1'b0;
                    end else if (opcode_s == OP_GOTO) begin
                        pc_q        <= target_s;
                        uop_q       <= {OP_NOP, 15'd0};
                        uop_valid_q <= 1'b0;
                    end else if ((opcode_s == OP_JZ) || (opcode_s == OP_JNZ)) begin
                        target_q    <= target_s;
                        br_is_jz_q  <= (opcode_s == OP_JZ);
                        uop_valid_q <= 1'b0;
                        state_q     <= ST_BR_EVAL;
                    end else if (opcode_s == OP_RVMEM) begin
                        // Acknowledge is not looked at until WAIT_VMEM.
                        uop_q       <= bus.iUop;
                        uop_valid_q <= 1'b1;
                        vmem_req_q  <= 1'b1;
                        state_q     <= ST_WAIT_VMEM;
                    end else begin
                        uop_q       <= bus.iUop;
                        uop_valid_q <= 1'b1;
                        pc_q        <= pc_inc_s;
                    end
                end
                ST_BR_EVAL: begin
                    uop_valid_q <= 1'b0;
                    if (bus.iStall) begin
                        state_q <= ST_BR_EVAL;
                    end else begin
                        pc_q    <= br_taken_s ? target_q : pc_inc_s;
                        state_q <= ST_RUN;
                    end
                end
                ST_WAIT_VMEM: begin
                    // Stall is deliberately ignored here; the request stays up.
                    uop_valid_q <= 1'b0;
                    if (bus.iVmemAck) begin
                        vmem_req_q <= 1'b0;
                        pc_q       <= pc_inc_s;
                        state_q    <= ST_RUN;
                    end else begin
                        vmem_req_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    pc_q        <= 8'd0;
                    uop_valid_q <= 1'b0;
                    vmem_req_q  <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/gpu_ucode_sequencer.md
GPU_UCODE_SEQUENCER -- requirements
Module: gpu_ucode_sequencer

Interface
REQ-001 SHALL have parameter START_ADDR, default 8'd1, meaning the ROM address loaded on start.
REQ-002 SHALL have parameters OP_GOTO, OP_JZ, OP_JNZ, OP_RVMEM and OP_NOP, each 5 bits, defaulting to the opcode values of `ggoto, `gjz, `gjnz, `grvmem and `gnop in gpu_definitions.v.
REQ-003 iClock  input  1  single clock; all state updates on rising edge.
REQ-004 iReset  input  1  reset, synchronous, active-high.
REQ-005 iStart  input  1  begin execution from START_ADDR (honoured in IDLE only).
REQ-006 iStop  input  1  request return to IDLE.
REQ-007 iStall  input  1  freeze sequencer (VRAM port held by another requester).
REQ-008 iZero  input  1  zero flag of the most recently executed uop.
REQ-009 iVmemAck  input  1  VRAM read data valid.
REQ-010 iUop  input  20  uop from ucode ROM; combinational from oAddr.
REQ-011 oAddr  output  8  ucode ROM address (= PC).
REQ-012 oUop  output  20  registered uop issued to the GPU execute stage.
REQ-013 oUopValid  output  1  oUop is to be executed this cycle.
REQ-014 oVmemReq  output  1  VRAM read request, level.
REQ-015 oBusy  output  1  high in every state except IDLE.

Function
REQ-016 Opcode SHALL be iUop[19:15]; branch target SHALL be iUop[7:0], with iUop[14:8] ignored.
REQ-017 The FSM SHALL have states IDLE, RUN, BR_EVAL and WAIT_VMEM.
REQ-018 IDLE: PC=0 and oUopValid=0; on iStart, PC<=START_ADDR and go to RUN next cycle.
REQ-019 RUN, no stall, ordinary opcode (including OP_NOP): oUop<=iUop, oUopValid<=1, PC<=PC+1.
REQ-020 RUN, OP_GOTO: PC<=target, oUop<=OP_NOP uop (all zero except opcode), oUopValid<=0; one-cycle cost.
REQ-021 RUN, OP_JZ or OP_JNZ: latch target, oUopValid<=0, go to BR_EVAL.
REQ-022 BR_EVAL: sample iZero.
- Taken (JZ with iZero=1, JNZ with iZero=0): PC<=target.
- Otherwise: PC<=PC+1.
- Return to RUN; oUopValid=0. Conditional branch costs 2 cycles.
REQ-023 RUN, OP_RVMEM: oUop<=iUop, oUopValid<=1 for exactly one cycle, oVmemReq<=1, go to WAIT_VMEM.
REQ-024 WAIT_VMEM: hold PC, oUopValid=0, oVmemReq=1. On iVmemAck: oVmemReq<=0, PC<=PC+1, go to RUN.
REQ-025 iVmemAck in the same cycle the request is raised SHALL NOT be accepted; acknowledgement is sampled only in WAIT_VMEM.
REQ-026 iStall=1 in RUN or BR_EVAL SHALL hold PC, state and latched target, and force oUopValid=0; BR_EVAL SHALL resample iZero after the stall ends.
REQ-027 iStall SHALL be ignored in WAIT_VMEM; oVmemReq stays asserted.
REQ-028 PC arithmetic SHALL be 8-bit; PC+1 from 8'hFF SHALL wrap to 8'h00.
REQ-029 iStop SHALL take effect at the next edge from any state: go to IDLE, PC<=0, oUopValid<=0, oVmemReq<=0. An outstanding VRAM request SHALL be abandoned.
REQ-030 If iStop and iStart are high together, iStop SHALL win.
REQ-031 oAddr SHALL equal PC combinationally; no other output is combinational.

Reset
REQ-032 On iReset=1 at a clock edge, in any state including mid-branch and mid-VRAM-wait:
- state=IDLE, PC=0, oUop=20'd0, oUopValid=0, oVmemReq=0, oBusy=0, latched target=0.
REQ-033 iReset SHALL have priority over iStop, iStart and all other inputs.

Verification
REQ-034 Reset, then iStart pulse -> next cycle oAddr=1, oBusy=1. With ROM 1..3 ordinary uops -> oUopValid=1 for three consecutive cycles, oUop equal to ROM[1..3].
REQ-035 ROM[5]=JNZ target 5 with iZero=0 for 3 evaluations, then iZero=1 -> PC revisits 5 three times, each visit 2 cycles with oUopValid=0, then PC=6.
REQ-036 ROM[6]=RVMEM, iVmemAck after 4 cycles -> oVmemReq high for 5 cycles, PC held at 6, PC=7 the cycle after ack.
REQ-037 ROM[8'hFF]=ordinary uop -> next PC=8'h00. GOTO at 0 with target 24 -> PC=24 after 1 cycle.
REQ-038 iStall high 3 cycles during RUN and during BR_EVAL -> PC, state and oUop frozen, oUopValid=0 throughout, then execution resumes unchanged.
REQ-039 iReset asserted in WAIT_VMEM, and separately iStop+iStart together in RUN -> IDLE, PC=0, oVmemReq=0, oBusy=0 next cycle.
